// File: rtl/imem_responder.sv
// Word-addressed instruction memory answering fetch requests with a four-phase req/valid handshake.
// Optional IMEM_RANGE_CHECK_EN adds addr_err and returns NOP for addresses outside the memory window.
module imem_responder #(
    parameter int                    DATA_WIDTH = 32,
    parameter int                    ADDR_BITS  = 10,
    parameter int                    LATENCY    = 2,
    parameter logic [DATA_WIDTH-1:0] BASE_ADDR  = '0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  inst_req,
    input  logic [DATA_WIDTH-1:0] inst_addr,
    output logic                  inst_valid,
    output logic [DATA_WIDTH-1:0] inst_data,
    input  logic                  load_en,
    input  logic [ADDR_BITS-1:0]  load_addr,
    input  logic [DATA_WIDTH-1:0] load_data,
    output logic                  busy
`ifdef IMEM_RANGE_CHECK_EN
    ,
    output logic                  addr_err
`endif
);

    localparam int                    DEPTH = 1 << ADDR_BITS;
    localparam logic [DATA_WIDTH-1:0] NOP   = DATA_WIDTH'(32'h00000013);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_VALID
    } state_t;

    state_t                  state_reg, state_next;
    logic [3:0]              cnt_reg, cnt_next;
    logic [ADDR_BITS-1:0]    idx_reg, idx_next;
    logic                    valid_reg, valid_next;
    logic [DATA_WIDTH-1:0]   data_reg, data_next;
    logic                    busy_reg;

    logic [DATA_WIDTH-1:0]   mem [DEPTH];
    logic [ADDR_BITS-1:0]    addr_idx;
    logic [ADDR_BITS-1:0]    rd_idx;
    logic [DATA_WIDTH-1:0]   rd_word;
    logic                    oor;
    logic                    pend_nop;

    assign addr_idx = ADDR_BITS'(inst_addr - BASE_ADDR);

`ifdef IMEM_RANGE_CHECK_EN
    logic [DATA_WIDTH:0] offset;
    logic                err_pend_reg, err_pend_next;
    logic                err_reg, err_next;

    // Extra MSB of the subtraction is the borrow, i.e. inst_addr below BASE_ADDR.
    assign offset   = {1'b0, inst_addr} - {1'b0, BASE_ADDR};
    assign oor      = offset[DATA_WIDTH] || ((offset[DATA_WIDTH-1:0] >> ADDR_BITS) != '0);
    assign pend_nop = err_pend_reg;
    assign addr_err = err_reg;
`else
    assign oor      = 1'b0;
    assign pend_nop = 1'b0;
`endif

    // The idle-state read uses the live address so LATENCY=1 can answer on the accept edge.
    assign rd_idx  = (state_reg == S_IDLE) ? addr_idx : idx_reg;
    assign rd_word = mem[rd_idx];

    always_ff @(posedge clk) begin
        if (load_en) begin
            mem[load_addr] <= load_data;
        end
    end

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        idx_next   = idx_reg;
        valid_next = valid_reg;
        data_next  = data_reg;
        case (state_reg)
            S_IDLE: begin
                valid_next = 1'b0;
                if (inst_req) begin
                    idx_next = addr_idx;
                    if (LATENCY == 1) begin
                        data_next  = oor ? NOP : rd_word;
                        valid_next = 1'b1;
                        state_next = S_VALID;
                    end else begin
                        cnt_next   = 4'(LATENCY - 1);
                        state_next = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                if (!inst_req) begin
                    state_next = S_IDLE;
                end else begin
                    cnt_next = cnt_reg - 4'd1;
                    if (cnt_reg == 4'd1) begin
                        data_next  = pend_nop ? NOP : rd_word;
                        valid_next = 1'b1;
                        state_next = S_VALID;
                    end
                end
            end
            S_VALID: begin
                if (!inst_req) begin
                    valid_next = 1'b0;
                    state_next = S_IDLE;
                end
            end
            default: begin
                valid_next = 1'b0;
                state_next = S_IDLE;
            end
        endcase
    end

`ifdef IMEM_RANGE_CHECK_EN
    always_comb begin
        err_pend_next = err_pend_reg;
        err_next      = 1'b0;
        if (state_reg == S_IDLE && inst_req) begin
            err_pend_next = oor;
        end
        if (valid_next) begin
            case (state_reg)
                S_IDLE:  err_next = oor;
                S_WAIT:  err_next = err_pend_reg;
                default: err_next = err_reg;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            err_pend_reg <= 1'b0;
            err_reg      <= 1'b0;
        end else begin
            err_pend_reg <= err_pend_next;
            err_reg      <= err_next;
        end
    end
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg <= S_IDLE;
            cnt_reg   <= '0;
            idx_reg   <= '0;
            valid_reg <= 1'b0;
            data_reg  <= '0;
            busy_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            idx_reg   <= idx_next;
            valid_reg <= valid_next;
            data_reg  <= data_next;
            busy_reg  <= (state_next != S_IDLE);
        end
    end

    assign inst_valid = valid_reg;
    assign inst_data  = data_reg;
    assign busy       = busy_reg;

endmodule

// File: tb/tb_imem_responder.sv
// Directed scoreboard bench for imem_responder: three instances cover LATENCY 2/3/1,
// a non-zero BASE_ADDR and a 4-bit index for wrap/range behaviour.
module tb_imem_responder;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [2:0]  req = '0;
    logic [31:0] addr [3];
    logic [2:0]  valid;
    logic [2:0]  busy;
    logic [31:0] data [3];
    logic        load_en   = 1'b0;
    logic [9:0]  load_addr = '0;
    logic [31:0] load_data = '0;

`ifdef IMEM_RANGE_CHECK_EN
    logic [2:0]  err;
    localparam logic [31:0] WRAP_EXP = 32'h00000013;
    localparam logic        WRAP_ERR = 1'b1;
`else
    localparam logic [31:0] WRAP_EXP = 32'hCAFE0003;
    localparam logic        WRAP_ERR = 1'b0;
`endif

    logic [31:0] sb [$];
    logic [31:0] vals [3] = '{32'h11, 32'h22, 32'h33};
    int          tests = 0;
    int          fails = 0;

    always #5 clk = ~clk;

    imem_responder #(.DATA_WIDTH(32), .ADDR_BITS(4), .LATENCY(2), .BASE_ADDR(32'h0)) u0 (
        .clk(clk), .rst(rst), .inst_req(req[0]), .inst_addr(addr[0]),
        .inst_valid(valid[0]), .inst_data(data[0]),
        .load_en(load_en), .load_addr(load_addr[3:0]), .load_data(load_data),
        .busy(busy[0])
`ifdef IMEM_RANGE_CHECK_EN
        , .addr_err(err[0])
`endif
    );

    imem_responder #(.DATA_WIDTH(32), .ADDR_BITS(10), .LATENCY(3), .BASE_ADDR(32'h100)) u1 (
        .clk(clk), .rst(rst), .inst_req(req[1]), .inst_addr(addr[1]),
        .inst_valid(valid[1]), .inst_data(data[1]),
        .load_en(load_en), .load_addr(load_addr), .load_data(load_data),
        .busy(busy[1])
`ifdef IMEM_RANGE_CHECK_EN
        , .addr_err(err[1])
`endif
    );

    imem_responder #(.DATA_WIDTH(32), .ADDR_BITS(4), .LATENCY(1), .BASE_ADDR(32'h0)) u2 (
        .clk(clk), .rst(rst), .inst_req(req[2]), .inst_addr(addr[2]),
        .inst_valid(valid[2]), .inst_data(data[2]),
        .load_en(load_en), .load_addr(load_addr[3:0]), .load_data(load_data),
        .busy(busy[2])
`ifdef IMEM_RANGE_CHECK_EN
        , .addr_err(err[2])
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic load(input logic [9:0] a, input logic [31:0] d);
        @(posedge clk); #1;
        load_en = 1'b1; load_addr = a; load_data = d;
        @(posedge clk); #1;
        load_en = 1'b0;
        $display("[TB] load mem[%0d] = %h", a, d);
    endtask

    // Full four-phase handshake; optional write to the same index on the accept edge.
    task automatic fetch(input int d, input logic [31:0] a, input logic [31:0] exp, input int lat,
                         input logic exp_err, input logic coll, input logic [31:0] coll_data);
        int          n;
        logic [31:0] want;
        @(posedge clk); #1;
        req[d] = 1'b1; addr[d] = a;
        sb.push_back(exp);
        if (coll) begin
            load_en = 1'b1; load_addr = a[9:0]; load_data = coll_data;
        end
        n = 0;
        while (n < 40) begin
            @(posedge clk); #1;
            n++;
            if (n == 1) begin
                addr[d] = ~a;
                load_en = 1'b0;
            end
            if (valid[d]) break;
        end
        want = sb.pop_front();
        chk("latency", 32'(n), 32'(lat));
        chk("data", data[d], want);
        chk("busy_valid", {31'd0, busy[d]}, 32'd1);
`ifdef IMEM_RANGE_CHECK_EN
        chk("addr_err", {31'd0, err[d]}, {31'd0, exp_err});
`endif
        $display("[TB] fetch dut%0d addr %h data %h lat %0d err_exp %0b", d, a, data[d], n, exp_err);
        req[d] = 1'b0;
        @(posedge clk); #1;
        chk("valid_fall", {31'd0, valid[d]}, 32'd0);
        chk("data_hold", data[d], want);
        chk("busy_idle", {31'd0, busy[d]}, 32'd0);
`ifdef IMEM_RANGE_CHECK_EN
        chk("addr_err_fall", {31'd0, err[d]}, 32'd0);
`endif
    endtask

    initial begin
        int   n;
        logic seen;
        for (int i = 0; i < 3; i++) addr[i] = '0;

        #2 rst = 1'b0;
        #1;
        for (int i = 0; i < 3; i++) begin
            chk("rst_valid", {31'd0, valid[i]}, 32'd0);
            chk("rst_busy", {31'd0, busy[i]}, 32'd0);
            chk("rst_data", data[i], 32'd0);
        end
        $display("[TB] reset state checked");

        // Preload while still in reset: memory writes are not gated by reset.
        load(10'd0, 32'hDEADBEEF);
        rst = 1'b1;

        fetch(0, 32'h0, 32'hDEADBEEF, 2, 1'b0, 1'b0, 32'h0);

        // Asynchronous reset while valid is high.
        @(posedge clk); #1;
        req[0] = 1'b1; addr[0] = 32'h0;
        n = 0;
        while (n < 40 && !valid[0]) begin
            @(posedge clk); #1;
            n++;
        end
        chk("pre_reset_valid", {31'd0, valid[0]}, 32'd1);
        #3 rst = 1'b0;
        #1;
        chk("async_rst_valid", {31'd0, valid[0]}, 32'd0);
        chk("async_rst_busy", {31'd0, busy[0]}, 32'd0);
        chk("async_rst_data", data[0], 32'd0);
        req[0] = 1'b0;
        $display("[TB] async reset during valid");
        @(posedge clk); #1;
        rst = 1'b1;
        fetch(0, 32'h0, 32'hDEADBEEF, 2, 1'b0, 1'b0, 32'h0);

        for (int i = 0; i < 3; i++) load(10'(i), vals[i]);
        for (int i = 0; i < 3; i++) fetch(0, 32'(i), vals[i], 2, 1'b0, 1'b0, 32'h0);

        // Non-zero base, LATENCY=3, then an aborted request.
        fetch(1, 32'h101, 32'h22, 3, 1'b0, 1'b0, 32'h0);
        @(posedge clk); #1;
        req[1] = 1'b1; addr[1] = 32'h100;
        @(posedge clk); #1;
        chk("abort_busy_accept", {31'd0, busy[1]}, 32'd1);
        req[1] = 1'b0;
        @(posedge clk); #1;
        chk("abort_busy_idle", {31'd0, busy[1]}, 32'd0);
        seen = 1'b0;
        repeat (4) begin
            if (valid[1]) seen = 1'b1;
            @(posedge clk); #1;
        end
        chk("abort_no_valid", {31'd0, seen}, 32'd0);
        chk("abort_data_kept", data[1], 32'h22);
        $display("[TB] abort dut1 valid_seen %0b data %h", seen, data[1]);

        // Address 0x13 on a 16-word memory: wraps to index 3, or NOP with range check.
        load(10'd3, 32'hCAFE0003);
        fetch(0, 32'h13, WRAP_EXP, 2, WRAP_ERR, 1'b0, 32'h0);
        fetch(0, 32'h3, 32'hCAFE0003, 2, 1'b0, 1'b0, 32'h0);

        // Read-before-write collision on the accept edge with LATENCY=1.
        load(10'd5, 32'h0000AAAA);
        fetch(2, 32'h5, 32'h0000AAAA, 1, 1'b0, 1'b1, 32'h0000BBBB);
        fetch(2, 32'h5, 32'h0000BBBB, 1, 1'b0, 1'b0, 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
